// File: rtl/rf_wb_arb.sv
// rtl/rf_wb_arb.sv - write-back arbiter and pending-write scoreboard for the register file
// Optional RF_WB_STATS_EN adds wr_count/conf_count statistics outputs.
module rf_wb_arb #(
  parameter int NREG = 16,
  parameter int DW   = 16,
  localparam int IW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            a_valid,
  input  logic [IW-1:0]   a_rd,
  input  logic [DW-1:0]   a_data,
  output logic            a_ready,
  input  logic            b_valid,
  input  logic [IW-1:0]   b_rd,
  input  logic [DW-1:0]   b_data,
  output logic            b_ready,
  input  logic            iss_valid,
  input  logic [IW-1:0]   iss_rd,
  output logic            we,
  output logic [IW-1:0]   Rd,
  output logic [DW-1:0]   writeData,
  output logic [NREG-1:0] pend
`ifdef RF_WB_STATS_EN
  ,
  output logic [15:0]     wr_count,
  output logic [15:0]     conf_count
`endif
);

  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

  logic            last_grant;
  logic            conflict;
  logic            grant_a;
  logic            grant_b;
  logic            xfer;
  logic [IW-1:0]   sel_rd;
  logic [DW-1:0]   sel_data;
  logic            sel_live;
  logic [NREG-1:0] pend_nxt;

  // On conflict the source that did not win last time gets the port.
  always_comb begin
    conflict = a_valid && b_valid;
    grant_a  = 1'b0;
    grant_b  = 1'b0;
    if (!rst) begin
      grant_a = a_valid && (!b_valid || (last_grant == GRANT_B));
      grant_b = b_valid && (!a_valid || (last_grant == GRANT_A));
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;
  assign xfer    = grant_a || grant_b;

  always_comb begin
    sel_rd   = grant_a ? a_rd   : b_rd;
    sel_data = grant_a ? a_data : b_data;
    sel_live = xfer && (sel_rd != '0);
  end

  // Issue sets after the transfer clear so a new producer keeps the bit pending.
  always_comb begin
    pend_nxt = pend;
    if (xfer)
      pend_nxt[sel_rd] = 1'b0;
    if (iss_valid)
      pend_nxt[iss_rd] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= GRANT_B;
      we         <= 1'b0;
      Rd         <= '0;
      writeData  <= '0;
      pend       <= '0;
    end else begin
      if (conflict)
        last_grant <= grant_a ? GRANT_A : GRANT_B;
      we   <= sel_live;
      pend <= pend_nxt;
      if (sel_live) begin
        Rd        <= sel_rd;
        writeData <= sel_data;
      end
    end
  end

`ifdef RF_WB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count   <= '0;
      conf_count <= '0;
    end else begin
      if (we)
        wr_count <= wr_count + 16'd1;
      if (conflict)
        conf_count <= conf_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/rf_wb_arb.md
# rf_wb_arb

Write-back arbiter and pending-write scoreboard for the 16 x 16-bit register file. Two result sources share the file's single write port: A (ALU) and B (load/memory). The block grants one source per cycle with round-robin on conflict and drives the registered write port (`we`, `Rd`, `writeData`). It also keeps a per-register pending mask that the issue stage uses for hazard stalls.

## Interface
Parameters:
- `NREG`, default 16: number of architectural registers; the index width is log2(NREG).
- `DW`, default 16: data width.

Ports:
- `clk`  in  1: clock; everything updates on posedge.
- `rst`  in  1: synchronous active-high reset.
- `a_valid`  in  1: ALU result available.
- `a_rd`  in  4: ALU destination register.
- `a_data`  in  16: ALU result.
- `a_ready`  out  1: A accepted this cycle (combinational).
- `b_valid`, `b_rd`, `b_data`, `b_ready`: same as the A ports, for the load source.
- `iss_valid`  in  1: the issue stage dispatches an instruction with a destination.
- `iss_rd`  in  4: destination register of the dispatched instruction.
- `we`  out  1: register-file write enable (registered).
- `Rd`  out  4: register-file write index (registered).
- `writeData`  out  16: register-file write data (registered).
- `pend`  out  16: bit i set means a write to register i is outstanding.

## Operation
- Handshake: a source must hold `valid`, `rd` and `data` stable until it sees `ready` high. A transfer happens when `valid` and `ready` are both high in the same cycle.
- Grant rules:
  - Only A valid: A is granted.
  - Only B valid: B is granted.
  - Both valid: the source opposite to `last_grant` is granted.
  - `last_grant` updates only on a conflict cycle. Reset value is B, so A wins the first conflict.
- Readiness: `a_ready` and `b_ready` are combinational from the valids and `last_grant`. At most one is high in any cycle, and neither is high when its valid is low.
- Write port: the cycle after a transfer, `we`=1 and `Rd`/`writeData` carry the granted `rd`/`data`. With no transfer, `we`=0 and `Rd`/`writeData` hold their previous values.
- Register 0: a transfer with `rd`=0 is accepted (ready asserts) but produces `we`=0.
- Same register from both sources: both writes are performed, one per cycle, in grant order. The later write wins.
- Scoreboard `pend`:
  - Set: `iss_valid` sets bit `iss_rd`.
  - Clear: a transfer clears bit `rd`, at the same edge that latches the write.
  - Set and clear of the same bit at the same edge: set wins (new outstanding producer).
  - Bit 0 is always 0.
- Reset mid-transfer: the transfer is discarded; no write is issued after reset deasserts.

## Timing
- Reset values: `we`=0, `Rd`=0, `writeData`=0, `pend`=0, `last_grant`=B, all counters 0. `a_ready`/`b_ready` are 0 while `rst`=1.
- Latency: transfer at edge N → `we` high during cycle N+1 → register file updates at edge N+1.
- Throughput: one write per cycle. On continuous conflict, A and B alternate every cycle, so a source waits at most 1 cycle.
- Scoreboard timing: `pend` reflects a set or clear one cycle after the edge that caused it. The bit is cleared in the same cycle `we` is asserted for that register.

## Configuration
- `RF_WB_STATS_EN` defined: adds output ports `wr_count` (out, 16) and `conf_count` (out, 16).
  - `wr_count` increments on every cycle with `we`=1.
  - `conf_count` increments on every cycle where `a_valid` and `b_valid` are both high.
  - Both wrap at 0xFFFF → 0 and reset to 0.
- `RF_WB_STATS_EN` undefined: those ports and counters are absent. All other behaviour is identical.

## Test plan
- Reset check: hold `rst`=1 for 2 cycles with all valids high.
  - Required: `we`=0, `pend`=0x0000, both readies 0.
  - After release, A is granted first.
- Single source: A valid, `rd`=3, `data`=0x1234.
  - Required: `a_ready`=1 at edge N.
  - Required: `we`=1, `Rd`=3, `writeData`=0x1234 in cycle N+1, then `we`=0.
- Continuous conflict: A writes r1 and B writes r2, both held valid for 4 transfers.
  - Required: grants A,B,A,B; `writeData` alternates accordingly.
  - Required with stats enabled: `conf_count`=4.
- Register 0 drop: B valid, `rd`=0, `data`=0xBEEF.
  - Required: `b_ready`=1, `we` stays 0, `pend[0]` stays 0.
- Scoreboard: `iss_valid` with `iss_rd`=5.
  - Required: `pend`=0x0020.
  - Then A writes r5 while `iss_valid`, `iss_rd`=5 in the same cycle: `pend[5]` stays 1.
  - A later write with no new issue clears it to 0x0000.
- Stats wrap (stats enabled): preload 0xFFFE writes via forced sequence, then issue 2 more writes.
  - Required: `wr_count` reads 0xFFFF, then 0x0000.
